// File: rtl/rvfi_dmem_model.sv
// Word-addressed data memory model with bounded, externally requested stalls and
// a sticky checker that flags requests changing while they are being stalled.
module rvfi_dmem_model #(
  parameter int WORDS     = 16,
  parameter int MAX_STALL = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall_req,
  input  logic        dmem_ren,
  input  logic [31:0] dmem_raddr,
  output logic [31:0] dmem_rdata,
  input  logic        dmem_we,
  input  logic [31:0] dmem_waddr,
  input  logic [31:0] dmem_wdata,
  input  logic [3:0]  dmem_wstrb,
  output logic        dmem_stall,
  output logic [1:0]  stall_run,
  output logic        proto_err
);

  localparam int         AW      = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [1:0] MAX_RUN = 2'(MAX_STALL);

  logic [31:0] mem [WORDS];

  logic          req_p0;
  logic          acc_p0;
  logic [AW-1:0] ridx_p0;
  logic [AW-1:0] widx_p0;

  logic          stall_p1;
  logic          ren_p1;
  logic          we_p1;
  logic [31:0]   raddr_p1;
  logic [31:0]   waddr_p1;
  logic [31:0]   wdata_p1;
  logic [3:0]    wstrb_p1;
  logic          changed_p0;

  // Request decode: stall is purely combinational from the current request.
  always_comb begin
    req_p0     = dmem_ren | dmem_we;
    dmem_stall = ~reset & stall_req & req_p0 & (stall_run < MAX_RUN);
    acc_p0     = ~reset & req_p0 & ~dmem_stall;
    ridx_p0    = dmem_raddr[AW+1:2];
    widx_p0    = dmem_waddr[AW+1:2];
    changed_p0 = (dmem_ren   != ren_p1)   | (dmem_we    != we_p1)    |
                 (dmem_raddr != raddr_p1) | (dmem_waddr != waddr_p1) |
                 (dmem_wdata != wdata_p1) | (dmem_wstrb != wstrb_p1);
  end

  // Stage p1: stall counter, request capture and protocol checker.
  always_ff @(posedge clock) begin
    if (reset) begin
      stall_run <= 2'd0;
      proto_err <= 1'b0;
      stall_p1  <= 1'b0;
      ren_p1    <= 1'b0;
      we_p1     <= 1'b0;
      raddr_p1  <= 32'h0;
      waddr_p1  <= 32'h0;
      wdata_p1  <= 32'h0;
      wstrb_p1  <= 4'h0;
    end else begin
      stall_run <= dmem_stall ? stall_run + 2'd1 : 2'd0;
      if (stall_p1 && changed_p0)
        proto_err <= 1'b1;
      stall_p1  <= dmem_stall;
      ren_p1    <= dmem_ren;
      we_p1     <= dmem_we;
      raddr_p1  <= dmem_raddr;
      waddr_p1  <= dmem_waddr;
      wdata_p1  <= dmem_wdata;
      wstrb_p1  <= dmem_wstrb;
    end
  end

  // Memory array and read register; nonblocking updates give read-first
  // behaviour when read and write hit the same word on one edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      dmem_rdata <= 32'h0;
      for (int i = 0; i < WORDS; i++)
        mem[i] <= 32'h0;
    end else if (acc_p0) begin
      if (dmem_ren)
        dmem_rdata <= mem[ridx_p0];
      if (dmem_we) begin
        for (int n = 0; n < 4; n++)
          if (dmem_wstrb[n])
            mem[widx_p0][8*n +: 8] <= dmem_wdata[8*n +: 8];
      end
    end
  end

endmodule

// File: tb/tb_rvfi_dmem_model.sv
// Directed testbench for rvfi_dmem_model (WORDS=16, MAX_STALL=2).
module tb_rvfi_dmem_model;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall_req;
  logic        dmem_ren;
  logic [31:0] dmem_raddr;
  logic [31:0] dmem_rdata;
  logic        dmem_we;
  logic [31:0] dmem_waddr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_stall;
  logic [1:0]  stall_run;
  logic        proto_err;

  int n_tests = 0;
  int n_fail  = 0;

  rvfi_dmem_model #(.WORDS(16), .MAX_STALL(2)) dut (
    .clock      (clock),
    .reset      (reset),
    .stall_req  (stall_req),
    .dmem_ren   (dmem_ren),
    .dmem_raddr (dmem_raddr),
    .dmem_rdata (dmem_rdata),
    .dmem_we    (dmem_we),
    .dmem_waddr (dmem_waddr),
    .dmem_wdata (dmem_wdata),
    .dmem_wstrb (dmem_wstrb),
    .dmem_stall (dmem_stall),
    .stall_run  (stall_run),
    .proto_err  (proto_err)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    dmem_ren = 1'b0; dmem_we = 1'b0; stall_req = 1'b0;
    dmem_raddr = 32'h0; dmem_waddr = 32'h0; dmem_wdata = 32'h0; dmem_wstrb = 4'h0;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    idle();
    dmem_we = 1'b1; dmem_waddr = a; dmem_wdata = d; dmem_wstrb = s;
    tick();
  endtask

  task automatic rd(input logic [31:0] a);
    idle();
    dmem_ren = 1'b1; dmem_raddr = a;
    tick();
  endtask

  initial begin
    idle();
    reset = 1'b1;
    // Request present during reset: no stall, and the write must be dropped.
    stall_req = 1'b1; dmem_we = 1'b1; dmem_waddr = 32'h0; dmem_wdata = 32'hFFFF_FFFF;
    dmem_wstrb = 4'hF; dmem_ren = 1'b1;
    #1;
    check("stall_in_reset", {31'h0, dmem_stall}, 32'h0);
    tick();
    tick();
    check("rst_rdata", dmem_rdata, 32'h0);
    check("rst_run", {30'h0, stall_run}, 32'h0);
    check("rst_perr", {31'h0, proto_err}, 32'h0);
    reset = 1'b0;
    idle();

    stall_req = 1'b1;
    #1;
    check("no_req_no_stall", {31'h0, dmem_stall}, 32'h0);
    rd(32'h0);
    check("reset_write_dropped", dmem_rdata, 32'h0);

    wr(32'h08, 32'hDEAD_BEEF, 4'hF);
    rd(32'h08);
    check("wr_rd_08", dmem_rdata, 32'hDEAD_BEEF);

    wr(32'h04, 32'h1122_3344, 4'hF);
    wr(32'h04, 32'hAA00_0000, 4'h8);
    rd(32'h04);
    check("strb_merge", dmem_rdata, 32'hAA22_3344);
    rd(32'h44);
    check("alias_44", dmem_rdata, 32'hAA22_3344);
    wr(32'h04, 32'hFFFF_FFFF, 4'h0);
    rd(32'h07);
    check("strb_zero", dmem_rdata, 32'hAA22_3344);

    // Bounded stall sequence on a read of word 0.
    wr(32'h00, 32'hCAFE_F00D, 4'hF);
    rd(32'h08);
    idle();
    stall_req = 1'b1; dmem_ren = 1'b1; dmem_raddr = 32'h0;
    #1;
    check("stall_c0", {31'h0, dmem_stall}, 32'h1);
    check("run_c0", {30'h0, stall_run}, 32'h0);
    tick();
    check("stall_c1", {31'h0, dmem_stall}, 32'h1);
    check("run_c1", {30'h0, stall_run}, 32'h1);
    check("hold_c1", dmem_rdata, 32'hDEAD_BEEF);
    tick();
    check("stall_c2", {31'h0, dmem_stall}, 32'h0);
    check("run_c2", {30'h0, stall_run}, 32'h2);
    check("hold_c2", dmem_rdata, 32'hDEAD_BEEF);
    tick();
    check("run_c3", {30'h0, stall_run}, 32'h0);
    check("rdata_c3", dmem_rdata, 32'hCAFE_F00D);
    check("perr_clean", {31'h0, proto_err}, 32'h0);
    idle();

    // Read-first on same word, then concurrent read/write to different words.
    wr(32'h0C, 32'h7, 4'hF);
    idle();
    dmem_ren = 1'b1; dmem_raddr = 32'h0C;
    dmem_we = 1'b1; dmem_waddr = 32'h0C; dmem_wdata = 32'h5; dmem_wstrb = 4'hF;
    tick();
    check("read_first", dmem_rdata, 32'h7);
    rd(32'h0C);
    check("after_write", dmem_rdata, 32'h5);
    idle();
    dmem_ren = 1'b1; dmem_raddr = 32'h08;
    dmem_we = 1'b1; dmem_waddr = 32'h10; dmem_wdata = 32'h1234_5678; dmem_wstrb = 4'hF;
    tick();
    check("dual_rd", dmem_rdata, 32'hDEAD_BEEF);
    rd(32'h10);
    check("dual_wr", dmem_rdata, 32'h1234_5678);

    // Changing the address mid-stall must raise a sticky protocol error.
    idle();
    stall_req = 1'b1; dmem_ren = 1'b1; dmem_raddr = 32'h0;
    tick();
    check("perr_before", {31'h0, proto_err}, 32'h0);
    dmem_raddr = 32'h4;
    tick();
    check("perr_set", {31'h0, proto_err}, 32'h1);
    idle();
    tick();
    tick();
    check("perr_sticky", {31'h0, proto_err}, 32'h1);

    // Reset in the middle of a stall.
    stall_req = 1'b1; dmem_ren = 1'b1; dmem_raddr = 32'h08;
    tick();
    check("mid_run", {30'h0, stall_run}, 32'h1);
    reset = 1'b1;
    #1;
    check("stall_rst_mid", {31'h0, dmem_stall}, 32'h0);
    tick();
    reset = 1'b0;
    check("mid_rst_run", {30'h0, stall_run}, 32'h0);
    check("mid_rst_rdata", dmem_rdata, 32'h0);
    check("mid_rst_perr", {31'h0, proto_err}, 32'h0);
    rd(32'h08);
    check("mem_clr_08", dmem_rdata, 32'h0);
    rd(32'h10);
    check("mem_clr_10", dmem_rdata, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
